// File: rtl/wdt_pkg.sv
// wdt_pkg: watchdog register map, control bit positions and sequencer state encoding
package wdt_pkg;
  localparam logic [2:0] WD_STATUS = 3'd0;
  localparam logic [2:0] WD_CONTROL = 3'd1;
  localparam logic [2:0] WD_PERIOD_L = 3'd2;
  localparam logic [2:0] WD_PERIOD_H = 3'd3;
  localparam int ITO = 0;
  localparam int CONT = 1;
  localparam int START = 2;
  localparam int STOP = 3;
  typedef enum logic [2:0] {IDLE, CFG, RUN, KICK, IRQ_RD, IRQ_CAP, IRQ_CLR} state_t;
endpackage

// File: rtl/wdt_heartbeat_sequencer_bus_driver.sv
// wdt_bus_driver: registers one single-cycle Avalon-MM read or write per request
module wdt_bus_driver (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_address,
  input  logic [15:0] req_writedata,
  output logic [2:0]  wd_address,
  output logic        wd_chipselect,
  output logic        wd_write_n,
  output logic [15:0] wd_writedata
);
  always_ff @(posedge clk)
    if (reset) begin
      wd_chipselect <= 1'b0;
      wd_write_n <= 1'b1;
      wd_address <= '0;
      wd_writedata <= '0;
    end else begin
      wd_chipselect <= req_valid;
      wd_write_n <= !(req_valid && req_write);
      wd_address <= req_valid ? req_address : '0;
      wd_writedata <= (req_valid && req_write) ? req_writedata : '0;
    end
endmodule

// File: rtl/wdt_heartbeat_sequencer.sv
// wdt_heartbeat_sequencer: arms the watchdog, kicks it once every client has checked in, services its IRQ
module wdt_heartbeat_sequencer import wdt_pkg::*; #(
  parameter int NUM_CLIENTS = 4,
  parameter logic [15:0] CTRL_WORD = 16'h0005,
  parameter int MIN_KICK_GAP = 64,
  parameter int GAP_W = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   arm,
  input  logic [NUM_CLIENTS-1:0] hb,
  input  logic                   force_kick,
  output logic [2:0]             wd_address,
  output logic                   wd_chipselect,
  output logic                   wd_write_n,
  output logic [15:0]            wd_writedata,
  input  logic [15:0]            wd_readdata,
  input  logic                   wd_irq,
  output logic                   armed,
  output logic [NUM_CLIENTS-1:0] pending_mask,
  output logic                   timeout_pulse,
  output logic [7:0]             timeout_count,
  output logic [1:0]             last_status
);
  state_t state, next_state;
  logic force_latched;
  logic [GAP_W-1:0] gap;
  logic kick_req;
  logic req_valid, req_write;
  logic [2:0] req_address;
  logic [15:0] req_writedata;
  logic unused_readdata;
  assign unused_readdata = ^wd_readdata[15:2];
  // a heartbeat landing this cycle already counts toward completing the mask
  assign kick_req = ((pending_mask & ~hb) == '0) || force_latched;
  always_ff @(posedge clk)
    state <= reset ? IDLE : next_state;
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    next_state = arm ? CFG : IDLE;
      CFG:     next_state = RUN;
      RUN:     next_state = wd_irq ? IRQ_RD : (kick_req && gap == '0) ? KICK : RUN;
      KICK:    next_state = RUN;
      IRQ_RD:  next_state = IRQ_CAP;
      IRQ_CAP: next_state = IRQ_CLR;
      IRQ_CLR: next_state = RUN;
      default: next_state = IDLE;
    endcase
  end
  // bus requests decode the upcoming state so the registered bus lines up with it
  always_comb begin
    req_valid = next_state inside {CFG, KICK, IRQ_RD, IRQ_CLR};
    req_write = next_state inside {CFG, KICK, IRQ_CLR};
    req_address = next_state == CFG ? WD_CONTROL : next_state == KICK ? WD_PERIOD_L : WD_STATUS;
    req_writedata = next_state == CFG ? CTRL_WORD : '0;
  end
  always_ff @(posedge clk)
    if (reset) begin
      armed <= 1'b0;
      pending_mask <= '1;
      force_latched <= 1'b0;
      gap <= '0;
      timeout_pulse <= 1'b0;
      timeout_count <= '0;
      last_status <= '0;
    end else begin
      armed <= armed || state == CFG;
      pending_mask <= state == IDLE ? pending_mask : (state == KICK ? '1 : pending_mask) & ~hb;
      force_latched <= state != IDLE && (force_kick || (force_latched && state != KICK));
      gap <= state == KICK ? GAP_W'(MIN_KICK_GAP) : gap - GAP_W'(gap != '0);
      timeout_pulse <= next_state == IRQ_CLR;
      timeout_count <= timeout_count + 8'(next_state == IRQ_CLR && timeout_count != 8'hFF);
      if (state == IRQ_CAP) last_status <= wd_readdata[1:0];
    end
  wdt_bus_driver u_bus (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_address(req_address),
    .req_writedata(req_writedata),
    .wd_address(wd_address),
    .wd_chipselect(wd_chipselect),
    .wd_write_n(wd_write_n),
    .wd_writedata(wd_writedata)
  );
endmodule

// File: tb/tb_wdt_heartbeat_sequencer.sv
// tb_wdt_heartbeat_sequencer: scoreboard of expected bus transactions plus direct output checks
module tb_wdt_heartbeat_sequencer;
  import wdt_pkg::*;
  localparam int N = 4;
  localparam int GAP = 64;
  logic clk = 0, reset = 1, arm = 0, force_kick = 0, wd_irq = 0;
  logic [N-1:0] hb = '0;
  logic [2:0] wd_address;
  logic wd_chipselect, wd_write_n;
  logic [15:0] wd_writedata;
  logic [15:0] wd_readdata = '0;
  logic armed, timeout_pulse;
  logic [N-1:0] pending_mask;
  logic [7:0] timeout_count;
  logic [1:0] last_status;
  logic [15:0] status_val = 16'h0003;
  logic [19:0] obs;
  logic [19:0] exp_q[$];
  int tests = 0, fails = 0, cyc = 0, kick_last = -1, kick_prev = -1, hb_cyc = 0;
  bit ok;

  wdt_heartbeat_sequencer #(.NUM_CLIENTS(N), .CTRL_WORD(16'h0005), .MIN_KICK_GAP(GAP), .GAP_W(7)) dut (
    .clk(clk), .reset(reset), .arm(arm), .hb(hb), .force_kick(force_kick),
    .wd_address(wd_address), .wd_chipselect(wd_chipselect), .wd_write_n(wd_write_n),
    .wd_writedata(wd_writedata), .wd_readdata(wd_readdata), .wd_irq(wd_irq),
    .armed(armed), .pending_mask(pending_mask), .timeout_pulse(timeout_pulse),
    .timeout_count(timeout_count), .last_status(last_status)
  );

  always #5 clk = ~clk;

  // watchdog slave model: registered readdata of the status register
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wd_chipselect && wd_write_n && wd_address == WD_STATUS) wd_readdata <= status_val;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (wd_chipselect) begin
      obs = {!wd_write_n, wd_address, wd_write_n ? 16'h0 : wd_writedata};
      if (exp_q.size() == 0) check("sb_unexpected", {12'h0, obs}, 32'hDEADBEEF);
      else check("sb_txn", {12'h0, obs}, {12'h0, exp_q.pop_front()});
      if (!wd_write_n && wd_address == WD_PERIOD_L) begin
        kick_prev = kick_last;
        kick_last = cyc;
      end
    end

  task automatic push(input logic w, input logic [2:0] a, input logic [15:0] d);
    exp_q.push_back({w, a, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_bus(input logic w, input logic [2:0] a, input string tag);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      ok = wd_chipselect && (wd_write_n == !w) && wd_address == a;
    end
    check(tag, ok, 1);
  endtask

  task automatic service_irq(input string tag);
    push(0, WD_STATUS, 0);
    push(1, WD_STATUS, 0);
    wd_irq = 1;
    wait_bus(1, WD_STATUS, tag);
    wd_irq = 0;
    tick();
  endtask

  initial begin
    ticks(5);
    check("rst_cs", wd_chipselect, 0);
    check("rst_write_n", wd_write_n, 1);
    check("rst_addr", wd_address, 0);
    check("rst_wdata", wd_writedata, 0);
    check("rst_armed", armed, 0);
    check("rst_mask", pending_mask, 4'hF);
    check("rst_pulse", timeout_pulse, 0);
    check("rst_count", timeout_count, 0);
    check("rst_status", last_status, 0);
    reset = 0;
    tick();
    arm = 1;
    push(1, WD_CONTROL, 16'h0005);
    tick();
    check("cfg_cs", wd_chipselect, 1);
    check("armed_early", armed, 0);
    tick();
    check("armed", armed, 1);
    check("cfg_cs_drop", wd_chipselect, 0);
    ticks(2);
    push(1, WD_PERIOD_L, 0);
    for (int i = 0; i < N; i++) begin
      hb = N'(1 << i);
      hb_cyc = cyc;
      tick();
      hb = '0;
      tick();
    end
    check("kick_latency", kick_last - hb_cyc, 1);
    check("mask_reload", pending_mask, 4'hF);
    push(1, WD_PERIOD_L, 0);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) begin
        hb = N'(1 << i);
        tick();
        hb = '0;
      end
    wait_bus(1, WD_PERIOD_L, "kick2_wait");
    tick();
    check("kick_gap", (kick_last - kick_prev) >= GAP && (kick_last - kick_prev) <= GAP + 2, 1);
    status_val = 16'h0003;
    push(0, WD_STATUS, 0);
    push(1, WD_STATUS, 0);
    wd_irq = 1;
    tick();
    check("irq_rd", {wd_chipselect, wd_write_n, wd_address}, {1'b1, 1'b1, WD_STATUS});
    tick();
    check("irq_cap_cs", wd_chipselect, 0);
    tick();
    check("irq_clr", {wd_chipselect, wd_write_n, wd_address}, {1'b1, 1'b0, WD_STATUS});
    check("irq_status", last_status, 2'b11);
    check("irq_pulse", timeout_pulse, 1);
    check("irq_count", timeout_count, 1);
    wd_irq = 0;
    tick();
    check("irq_pulse_drop", timeout_pulse, 0);
    check("irq_no_reservice", wd_chipselect, 0);
    ticks(70);
    status_val = 16'h0002;
    push(0, WD_STATUS, 0);
    push(1, WD_STATUS, 0);
    push(1, WD_PERIOD_L, 0);
    wd_irq = 1;
    hb = '1;
    tick();
    hb = '0;
    wait_bus(1, WD_STATUS, "prio_clr");
    wd_irq = 0;
    check("prio_status", last_status, 2'b10);
    check("prio_count", timeout_count, 2);
    wait_bus(1, WD_PERIOD_L, "prio_kick");
    hb = 4'b0100;
    tick();
    hb = '0;
    check("kick_hb_kept", pending_mask, 4'hB);
    ticks(70);
    push(1, WD_PERIOD_L, 0);
    force_kick = 1;
    tick();
    force_kick = 0;
    wait_bus(1, WD_PERIOD_L, "force_kick");
    tick();
    check("force_mask", pending_mask, 4'hF);
    status_val = 16'h0001;
    for (int i = 2; i < 260; i++) begin
      service_irq("sat_service");
      if (i == 254) check("count_255", timeout_count, 255);
    end
    check("count_sat", timeout_count, 255);
    check("sat_status", last_status, 2'b01);
    push(0, WD_STATUS, 0);
    wd_irq = 1;
    tick();
    check("mid_rd_cs", wd_chipselect, 1);
    reset = 1;
    wd_irq = 0;
    arm = 0;
    tick();
    check("mid_rst_cs", wd_chipselect, 0);
    check("mid_rst_armed", armed, 0);
    check("mid_rst_count", timeout_count, 0);
    check("mid_rst_mask", pending_mask, 4'hF);
    ticks(2);
    reset = 0;
    ticks(5);
    check("idle_no_bus", wd_chipselect, 0);
    check("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
